// File: rtl/rename_map_table.sv
// Register alias table: maps each architectural register to the ARF or to a
// ROB tag with a ready bit, with zero-latency multi-slot rename lookups.
module rename_map_table #(
    parameter int unsigned N_ARCH     = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned DISPATCH_W = 2,
    localparam int unsigned REG_W     = $clog2(N_ARCH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [DISPATCH_W-1:0]       disp_valid_i,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rs1_i,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rs2_i,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rd_i,
    input  logic [DISPATCH_W*TAG_W-1:0] disp_tag_i,
    input  logic                        cdb_valid_i,
    input  logic [TAG_W-1:0]            cdb_tag_i,
    input  logic                        commit_valid_i,
    input  logic [REG_W-1:0]            commit_rd_i,
    input  logic [TAG_W-1:0]            commit_tag_i,
    output logic [DISPATCH_W-1:0]       src1_mapped_o,
    output logic [DISPATCH_W*TAG_W-1:0] src1_tag_o,
    output logic [DISPATCH_W-1:0]       src1_ready_o,
    output logic [DISPATCH_W-1:0]       src2_mapped_o,
    output logic [DISPATCH_W*TAG_W-1:0] src2_tag_o,
    output logic [DISPATCH_W-1:0]       src2_ready_o
);

    // Per-entry state: mapped=0 is ARF, mapped=1/ready=0 is PEND, mapped=1/ready=1 is READY.
    logic [N_ARCH-1:0] mapped_q, mapped_d;
    logic [N_ARCH-1:0] ready_q, ready_d;
    logic [TAG_W-1:0]  tag_q [N_ARCH];
    logic [TAG_W-1:0]  tag_d [N_ARCH];

    // Resolve one source for a slot; returns {mapped, ready, tag}.
    function automatic logic [TAG_W+1:0] lookup(input int unsigned slot,
                                                input logic [REG_W-1:0] src);
        logic             hit;
        logic             m;
        logic             r;
        logic [TAG_W-1:0] t;
        hit = 1'b0;
        m   = 1'b0;
        r   = 1'b0;
        t   = '0;
        // Later (younger) older-slots overwrite earlier matches.
        for (int unsigned i = 0; i < DISPATCH_W; i++) begin
            if (i < slot && disp_valid_i[i] && disp_rd_i[i*REG_W +: REG_W] == src) begin
                hit = 1'b1;
                t   = disp_tag_i[i*TAG_W +: TAG_W];
            end
        end
        if (src == '0) begin
            t = '0;
        end else if (hit) begin
            // Tag allocated this cycle cannot complete this cycle: no CDB bypass.
            m = 1'b1;
        end else if (mapped_q[src]) begin
            m = 1'b1;
            t = tag_q[src];
            r = ready_q[src] | (cdb_valid_i && cdb_tag_i == tag_q[src]);
        end
        return {m, r, t};
    endfunction

    // Combinational rename lookups for every slot and both sources.
    always_comb begin
        src1_mapped_o = '0;
        src1_ready_o  = '0;
        src1_tag_o    = '0;
        src2_mapped_o = '0;
        src2_ready_o  = '0;
        src2_tag_o    = '0;
        for (int unsigned j = 0; j < DISPATCH_W; j++) begin
            {src1_mapped_o[j], src1_ready_o[j], src1_tag_o[j*TAG_W +: TAG_W]} =
                lookup(j, disp_rs1_i[j*REG_W +: REG_W]);
            {src2_mapped_o[j], src2_ready_o[j], src2_tag_o[j*TAG_W +: TAG_W]} =
                lookup(j, disp_rs2_i[j*REG_W +: REG_W]);
        end
    end

    // Next-state: CDB, then commit, then dispatch, so later writes take priority.
    always_comb begin
        mapped_d = mapped_q;
        ready_d  = ready_q;
        tag_d    = tag_q;
        for (int unsigned r = 1; r < N_ARCH; r++) begin
            if (cdb_valid_i && mapped_q[r] && !ready_q[r] && cdb_tag_i == tag_q[r]) begin
                ready_d[r] = 1'b1;
            end
            if (commit_valid_i && commit_rd_i == REG_W'(r) && commit_tag_i == tag_q[r]) begin
                mapped_d[r] = 1'b0;
                ready_d[r]  = 1'b0;
                tag_d[r]    = '0;
            end
            for (int unsigned i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid_i[i] && disp_rd_i[i*REG_W +: REG_W] == REG_W'(r)) begin
                    mapped_d[r] = 1'b1;
                    ready_d[r]  = 1'b0;
                    tag_d[r]    = disp_tag_i[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    // Table state; reset and flush return every entry to ARF.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            mapped_q <= '0;
            ready_q  <= '0;
            for (int unsigned r = 0; r < N_ARCH; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            mapped_q <= mapped_d;
            ready_q  <= ready_d;
            for (int unsigned r = 0; r < N_ARCH; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Randomized bench for rename_map_table against a behavioural alias-table model.
module tb_rename_map_table;

    localparam int N_ARCH = 32;
    localparam int TAG_W  = 4;
    localparam int DW     = 2;
    localparam int REG_W  = $clog2(N_ARCH);

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [DW-1:0]         disp_valid;
    logic [DW*REG_W-1:0]   disp_rs1, disp_rs2, disp_rd;
    logic [DW*TAG_W-1:0]   disp_tag;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic                  commit_valid;
    logic [REG_W-1:0]      commit_rd;
    logic [TAG_W-1:0]      commit_tag;
    logic [DW-1:0]         src1_mapped, src1_ready, src2_mapped, src2_ready;
    logic [DW*TAG_W-1:0]   src1_tag, src2_tag;

    rename_map_table #(
        .N_ARCH     (N_ARCH),
        .TAG_W      (TAG_W),
        .DISPATCH_W (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush_i        (flush),
        .disp_valid_i   (disp_valid),
        .disp_rs1_i     (disp_rs1),
        .disp_rs2_i     (disp_rs2),
        .disp_rd_i      (disp_rd),
        .disp_tag_i     (disp_tag),
        .cdb_valid_i    (cdb_valid),
        .cdb_tag_i      (cdb_tag),
        .commit_valid_i (commit_valid),
        .commit_rd_i    (commit_rd),
        .commit_tag_i   (commit_tag),
        .src1_mapped_o  (src1_mapped),
        .src1_tag_o     (src1_tag),
        .src1_ready_o   (src1_ready),
        .src2_mapped_o  (src2_mapped),
        .src2_tag_o     (src2_tag),
        .src2_ready_o   (src2_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus for the current cycle, as plain integers.
    int s_reset, s_flush, s_cdb_v, s_cdb_t, s_com_v, s_com_rd, s_com_t;
    int s_valid[DW], s_rs1[DW], s_rs2[DW], s_rd[DW], s_tag[DW];

    // Model: state 0 = ARF, 1 = waiting for result, 2 = result in ROB.
    int m_state[N_ARCH];
    int m_tag[N_ARCH];

    task automatic check_eq(input string name, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (mapped*32+ready*16+tag)",
                     name, obs, exp);
        end
    endtask

    task automatic idle();
        s_reset = 0; s_flush = 0; s_cdb_v = 0; s_cdb_t = 0;
        s_com_v = 0; s_com_rd = 0; s_com_t = 0;
        for (int i = 0; i < DW; i++) begin
            s_valid[i] = 0; s_rs1[i] = 0; s_rs2[i] = 0; s_rd[i] = 0; s_tag[i] = 0;
        end
    endtask

    // Expected {mapped, ready, tag} packed as mapped*32 + ready*16 + tag.
    function automatic int exp_lookup(int slot, int src);
        int t;
        if (src == 0) return 0;
        t = -1;
        for (int i = 0; i < slot; i++)
            if (s_valid[i] != 0 && s_rd[i] == src) t = s_tag[i];
        if (t >= 0) return 32 + t;
        if (m_state[src] == 0) return 0;
        if (m_state[src] == 2) return 48 + m_tag[src];
        if (s_cdb_v != 0 && s_cdb_t == m_tag[src]) return 48 + m_tag[src];
        return 32 + m_tag[src];
    endfunction

    function automatic int obs1(int j);
        return 32 * int'(src1_mapped[j]) + 16 * int'(src1_ready[j])
               + int'(src1_tag[j*TAG_W +: TAG_W]);
    endfunction

    function automatic int obs2(int j);
        return 32 * int'(src2_mapped[j]) + 16 * int'(src2_ready[j])
               + int'(src2_tag[j*TAG_W +: TAG_W]);
    endfunction

    task automatic model_step();
        int w;
        if (s_reset != 0 || s_flush != 0) begin
            for (int r = 0; r < N_ARCH; r++) begin m_state[r] = 0; m_tag[r] = 0; end
            return;
        end
        for (int r = 1; r < N_ARCH; r++) begin
            w = -1;
            for (int i = 0; i < DW; i++) if (s_valid[i] != 0 && s_rd[i] == r) w = i;
            if (w >= 0) begin
                m_state[r] = 1; m_tag[r] = s_tag[w];
            end else if (s_com_v != 0 && s_com_rd == r && s_com_t == m_tag[r]) begin
                m_state[r] = 0; m_tag[r] = 0;
            end else if (m_state[r] == 1 && s_cdb_v != 0 && s_cdb_t == m_tag[r]) begin
                m_state[r] = 2;
            end
        end
    endtask

    // Drive at the falling edge, then compare every lookup against the model.
    task automatic begin_cycle(input bit do_check);
        @(negedge clock);
        reset        = (s_reset != 0);
        flush        = (s_flush != 0);
        cdb_valid    = (s_cdb_v != 0);
        cdb_tag      = TAG_W'(s_cdb_t);
        commit_valid = (s_com_v != 0);
        commit_rd    = REG_W'(s_com_rd);
        commit_tag   = TAG_W'(s_com_t);
        for (int i = 0; i < DW; i++) begin
            disp_valid[i]                 = (s_valid[i] != 0);
            disp_rs1[i*REG_W +: REG_W]    = REG_W'(s_rs1[i]);
            disp_rs2[i*REG_W +: REG_W]    = REG_W'(s_rs2[i]);
            disp_rd[i*REG_W +: REG_W]     = REG_W'(s_rd[i]);
            disp_tag[i*TAG_W +: TAG_W]    = TAG_W'(s_tag[i]);
        end
        #1;
        if (do_check) begin
            for (int j = 0; j < DW; j++) begin
                check_eq($sformatf("slot%0d_rs1_r%0d", j, s_rs1[j]), obs1(j), exp_lookup(j, s_rs1[j]));
                check_eq($sformatf("slot%0d_rs2_r%0d", j, s_rs2[j]), obs2(j), exp_lookup(j, s_rs2[j]));
            end
        end
    endtask

    task automatic end_cycle();
        @(posedge clock);
        model_step();
    endtask

    // Read back every table entry with no dispatch, CDB or commit activity.
    task automatic scan();
        for (int r = 0; r < N_ARCH; r += 4) begin
            idle();
            s_rs1[0] = r; s_rs2[0] = r + 1; s_rs1[1] = r + 2; s_rs2[1] = r + 3;
            begin_cycle(1); end_cycle();
        end
    endtask

    initial begin
        for (int r = 0; r < N_ARCH; r++) begin m_state[r] = 0; m_tag[r] = 0; end
        idle();
        s_reset = 1;
        begin_cycle(0); end_cycle();
        begin_cycle(0); end_cycle();

        // Reset state: all lookups unmapped.
        idle(); s_rs1[0] = 3; s_rs2[0] = 17; s_rs1[1] = 31; s_rs2[1] = 8;
        begin_cycle(1);
        check_eq("reset_outputs", int'({src1_mapped, src2_mapped, src1_ready, src2_ready,
                                        src1_tag, src2_tag}), 0);
        end_cycle();

        // Rename rd=5 tag=3, then CDB bypass, then READY.
        idle(); s_valid[0] = 1; s_rd[0] = 5; s_tag[0] = 3;
        begin_cycle(1); end_cycle();
        idle(); s_rs1[0] = 5;
        begin_cycle(1); check_eq("r5_pend", obs1(0), 32 + 3); end_cycle();
        idle(); s_rs1[0] = 5; s_cdb_v = 1; s_cdb_t = 3;
        begin_cycle(1); check_eq("r5_cdb_bypass", obs1(0), 48 + 3); end_cycle();
        idle(); s_rs1[0] = 5;
        begin_cycle(1); check_eq("r5_ready", obs1(0), 48 + 3); end_cycle();

        // Intra-group dependency, with a CDB on the same tag that must not bypass.
        idle(); s_valid[0] = 1; s_valid[1] = 1; s_rd[0] = 7; s_tag[0] = 2;
        s_rs1[1] = 7; s_rs2[1] = 7; s_cdb_v = 1; s_cdb_t = 2;
        begin_cycle(1);
        check_eq("intra_rs1", obs1(1), 32 + 2);
        check_eq("intra_rs2", obs2(1), 32 + 2);
        end_cycle();

        // Duplicate rd: youngest wins; stale commit ignored; matching commit frees.
        idle(); s_valid[0] = 1; s_valid[1] = 1; s_rd[0] = 9; s_tag[0] = 1;
        s_rd[1] = 9; s_tag[1] = 4;
        begin_cycle(1); end_cycle();
        idle(); s_com_v = 1; s_com_rd = 9; s_com_t = 1;
        begin_cycle(1); end_cycle();
        idle(); s_rs1[0] = 9;
        begin_cycle(1); check_eq("dup_stale_commit", obs1(0), 32 + 4); end_cycle();
        idle(); s_com_v = 1; s_com_rd = 9; s_com_t = 4; s_rs1[0] = 9;
        begin_cycle(1); check_eq("commit_no_bypass", obs1(0), 32 + 4); end_cycle();
        idle(); s_rs1[0] = 9;
        begin_cycle(1); check_eq("dup_committed", obs1(0), 0); end_cycle();

        // Collision: entry 6 READY(5); dispatch tag 8 beats commit tag 5.
        idle(); s_valid[0] = 1; s_rd[0] = 6; s_tag[0] = 5;
        begin_cycle(1); end_cycle();
        idle(); s_cdb_v = 1; s_cdb_t = 5;
        begin_cycle(1); end_cycle();
        idle(); s_valid[1] = 1; s_rd[1] = 6; s_tag[1] = 8; s_com_v = 1; s_com_rd = 6;
        s_com_t = 5;
        begin_cycle(1); end_cycle();
        idle(); s_rs1[0] = 6;
        begin_cycle(1); check_eq("collision", obs1(0), 32 + 8); end_cycle();

        // Flush discards dispatch and all mappings.
        idle(); s_flush = 1; s_valid[0] = 1; s_valid[1] = 1; s_rd[0] = 10; s_tag[0] = 11;
        s_rd[1] = 11; s_tag[1] = 12;
        begin_cycle(1); end_cycle();
        idle(); s_rs1[0] = 10; s_rs2[0] = 11; s_rs1[1] = 5; s_rs2[1] = 6;
        begin_cycle(1);
        check_eq("flush_r10", obs1(0), 0);
        check_eq("flush_r6", obs2(1), 0);
        end_cycle();
        scan();

        // Zero register is never mapped.
        idle(); s_valid[0] = 1; s_rd[0] = 0; s_tag[0] = 3;
        begin_cycle(1); end_cycle();
        idle(); s_rs1[0] = 0; s_rs1[1] = 0; s_rs2[1] = 0;
        begin_cycle(1); check_eq("zero_reg", obs1(0), 0); end_cycle();

        // Randomized traffic over a small register window to force collisions.
        for (int c = 0; c < 600; c++) begin
            int pr;
            idle();
            s_flush = ($urandom_range(0, 39) == 0) ? 1 : 0;
            s_reset = ($urandom_range(0, 99) == 0) ? 1 : 0;
            for (int i = 0; i < DW; i++) begin
                s_valid[i] = $urandom_range(0, 1);
                s_rs1[i]   = $urandom_range(0, 7);
                s_rs2[i]   = $urandom_range(0, 7);
                s_rd[i]    = $urandom_range(0, 7);
                s_tag[i]   = $urandom_range(0, 15);
            end
            s_cdb_v = $urandom_range(0, 1);
            pr = $urandom_range(1, 7);
            s_cdb_t = ($urandom_range(0, 3) != 0) ? m_tag[pr] : $urandom_range(0, 15);
            s_com_v = $urandom_range(0, 1);
            s_com_rd = $urandom_range(0, 7);
            s_com_t = ($urandom_range(0, 3) != 0) ? m_tag[s_com_rd] : $urandom_range(0, 15);
            begin_cycle(1); end_cycle();
            if (c % 100 == 99) scan();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
